trojan_scan_ctrl: RTL and testbench

Test-sequencing controller for the small combinational circuits under trojan analysis.
- Sweeps every input combination into a suspect instance and a golden instance in parallel.
- Waits a programmable settle time, then compares the two output vectors.
- Reports the mismatch count, the first failing vector and its differing output bits.
- Sits between the analysis host (start/done handshake) and a DUT/golden pair of identical interface.

---
 rtl/trojan_scan_if.sv | 40 ++++
 rtl/trojan_scan_ctrl.sv | 146 ++++++++++++++
 tb/tb_trojan_scan_ctrl.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/trojan_scan_if.sv
// Signal bundle between the analysis host, the scan controller and the DUT/golden pair.
// fail_map is present only when TROJAN_SCAN_MAP_EN is defined.
interface trojan_scan_if #(
  parameter int IN_W  = 3,
  parameter int OUT_W = 4,
  parameter int CNT_W = 8
);
  logic             start;
  logic             abort;
  logic [IN_W-1:0]  dut_in;
  logic [OUT_W-1:0] dut_out;
  logic [OUT_W-1:0] gold_out;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] mismatch_cnt;
  logic             trojan_flag;
  logic [IN_W-1:0]  fail_vec;
  logic [OUT_W-1:0] fail_diff;
`ifdef TROJAN_SCAN_MAP_EN
  logic [(1<<IN_W)-1:0] fail_map;

  modport master (
    output start, abort, dut_out, gold_out,
    input  dut_in, busy, done, mismatch_cnt, trojan_flag, fail_vec, fail_diff, fail_map
  );
  modport slave (
    input  start, abort, dut_out, gold_out,
    output dut_in, busy, done, mismatch_cnt, trojan_flag, fail_vec, fail_diff, fail_map
  );
`else
  modport master (
    output start, abort, dut_out, gold_out,
    input  dut_in, busy, done, mismatch_cnt, trojan_flag, fail_vec, fail_diff
  );
  modport slave (
    input  start, abort, dut_out, gold_out,
    output dut_in, busy, done, mismatch_cnt, trojan_flag, fail_vec, fail_diff
  );
`endif
endinterface

// File: rtl/trojan_scan_ctrl.sv
// Sweeps every input vector into a suspect/golden pair, compares after a settle time and
// records mismatches. Defining TROJAN_SCAN_MAP_EN adds a per-vector fail_map output.
module trojan_scan_ctrl #(
  parameter int IN_W   = 3,
  parameter int OUT_W  = 4,
  parameter int SETTLE = 2,
  parameter int PASSES = 1,
  parameter int CNT_W  = 8
) (
  input logic          clk,
  input logic          rst_n,
  trojan_scan_if.slave bus
);
  // state      | meaning
  // ST_IDLE    | waiting for an accepted start
  // ST_APPLY   | drive current vector onto dut_in
  // ST_SETTLE  | let both circuits settle for SETTLE cycles
  // ST_COMPARE | compare outputs, advance vector / pass
  // ST_DONE    | flag completion, park dut_in at 0

  localparam int SW = $clog2(SETTLE + 1);
  localparam int PW = $clog2(PASSES + 1);
  localparam logic [IN_W-1:0] VEC_LAST = {IN_W{1'b1}};

  typedef enum logic [2:0] {
    ST_IDLE, ST_APPLY, ST_SETTLE, ST_COMPARE, ST_DONE
  } state_t;

  state_t           state;
  logic [IN_W-1:0]  vec;
  logic [IN_W-1:0]  dut_in_q;
  logic [IN_W-1:0]  fail_vec_q;
  logic [SW-1:0]    settle_cnt;
  logic [PW-1:0]    pass;
  logic [OUT_W-1:0] diff;
  logic [OUT_W-1:0] fail_diff_q;
  logic [CNT_W-1:0] mismatch_cnt_q;
  logic             busy_q;
  logic             done_q;
  logic             seen;
  logic             accept;
  logic             cmp_fail;

  assign diff     = bus.dut_out ^ bus.gold_out;
  assign accept   = (state == ST_IDLE) && bus.start && !bus.abort;
  assign cmp_fail = (state == ST_COMPARE) && (diff != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      vec            <= '0;
      dut_in_q       <= '0;
      settle_cnt     <= '0;
      pass           <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      mismatch_cnt_q <= '0;
      fail_vec_q     <= '0;
      fail_diff_q    <= '0;
      seen           <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state          <= ST_APPLY;
            busy_q         <= 1'b1;
            done_q         <= 1'b0;
            mismatch_cnt_q <= '0;
            fail_vec_q     <= '0;
            fail_diff_q    <= '0;
            seen           <= 1'b0;
            vec            <= '0;
            pass           <= '0;
            settle_cnt     <= '0;
          end
        end
        ST_APPLY: begin
          dut_in_q   <= vec;
          settle_cnt <= SW'(SETTLE - 1);
          state      <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (settle_cnt == '0) state <= ST_COMPARE;
          else                  settle_cnt <= settle_cnt - 1'b1;
        end
        ST_COMPARE: begin
          if (cmp_fail) begin
            if (mismatch_cnt_q != {CNT_W{1'b1}}) mismatch_cnt_q <= mismatch_cnt_q + 1'b1;
            // only the first failure of a scan is kept for diagnosis
            if (!seen) begin
              seen        <= 1'b1;
              fail_vec_q  <= vec;
              fail_diff_q <= diff;
            end
          end
          if (vec != VEC_LAST) begin
            vec   <= vec + 1'b1;
            state <= ST_APPLY;
          end else begin
            vec <= '0;
            if (pass != PW'(PASSES - 1)) begin
              pass  <= pass + 1'b1;
              state <= ST_APPLY;
            end else begin
              state <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          done_q   <= 1'b1;
          dut_in_q <= '0;
          busy_q   <= 1'b0;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
      // abort overrides the step above but lets a same-cycle compare count
      if (state != ST_IDLE && bus.abort) begin
        state    <= ST_IDLE;
        busy_q   <= 1'b0;
        done_q   <= 1'b0;
        dut_in_q <= '0;
      end
    end
  end

`ifdef TROJAN_SCAN_MAP_EN
  logic [(1<<IN_W)-1:0] fail_map_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        fail_map_q      <= '0;
    else if (accept)   fail_map_q      <= '0;
    else if (cmp_fail) fail_map_q[vec] <= 1'b1;
  end

  assign bus.fail_map = fail_map_q;
`endif

  assign bus.dut_in       = dut_in_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.mismatch_cnt = mismatch_cnt_q;
  assign bus.trojan_flag  = (mismatch_cnt_q != '0);
  assign bus.fail_vec     = fail_vec_q;
  assign bus.fail_diff    = fail_diff_q;
endmodule

// File: tb/tb_trojan_scan_ctrl.sv
// Bench for trojan_scan_ctrl: three instances (default, PASSES=2, CNT_W=3) checked every
// cycle against a scan-position model, plus literal end-of-scan expectations.
module tb_trojan_scan_ctrl;
  logic clk;
  logic rst_n;
  logic start_v [3];
  logic abort_v [3];
  int   mode [3];

  int settle_p [3] = '{2, 2, 2};
  int passes_p [3] = '{1, 2, 1};
  int cntw_p   [3] = '{8, 8, 3};

  int act [3];
  int k [3];
  int cnt_e [3];
  int fv_e [3];
  int fd_e [3];
  int seen_e [3];
  int done_e [3];
  logic [7:0] map_e [3];

  int total_checks = 0;
  int passed = 0;

  trojan_scan_if #(.IN_W(3), .OUT_W(4), .CNT_W(8)) b0 ();
  trojan_scan_if #(.IN_W(3), .OUT_W(4), .CNT_W(8)) b1 ();
  trojan_scan_if #(.IN_W(3), .OUT_W(4), .CNT_W(3)) b2 ();

  trojan_scan_ctrl #(.IN_W(3), .OUT_W(4), .SETTLE(2), .PASSES(1), .CNT_W(8))
    u0 (.clk(clk), .rst_n(rst_n), .bus(b0.slave));
  trojan_scan_ctrl #(.IN_W(3), .OUT_W(4), .SETTLE(2), .PASSES(2), .CNT_W(8))
    u1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));
  trojan_scan_ctrl #(.IN_W(3), .OUT_W(4), .SETTLE(2), .PASSES(1), .CNT_W(3))
    u2 (.clk(clk), .rst_n(rst_n), .bus(b2.slave));

  // golden cell and injected fault patterns (mode 1: bit0 on vector 5, mode 2: all bits)
  function automatic logic [3:0] gold_fn(logic [2:0] v);
    return {v[2] & v[1], v[1] ^ v[0], v[2] | v[0], ~v[0]};
  endfunction

  function automatic logic [3:0] inj(int m, int v);
    if (m == 1) return (v == 5) ? 4'b0001 : 4'b0000;
    if (m == 2) return 4'b1111;
    return 4'b0000;
  endfunction

  assign b0.start = start_v[0];
  assign b0.abort = abort_v[0];
  assign b1.start = start_v[1];
  assign b1.abort = abort_v[1];
  assign b2.start = start_v[2];
  assign b2.abort = abort_v[2];
  assign b0.gold_out = gold_fn(b0.dut_in);
  assign b1.gold_out = gold_fn(b1.dut_in);
  assign b2.gold_out = gold_fn(b2.dut_in);
  assign b0.dut_out = gold_fn(b0.dut_in) ^ inj(mode[0], int'(b0.dut_in));
  assign b1.dut_out = gold_fn(b1.dut_in) ^ inj(mode[1], int'(b1.dut_in));
  assign b2.dut_out = gold_fn(b2.dut_in) ^ inj(mode[2], int'(b2.dut_in));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(string name, int actual, int required);
    total_checks++;
    if (actual == required) passed++;
    else $display("FAIL %s actual=%0d required=%0d", name, actual, required);
  endtask

  // Model: k counts cycles since the accepted start; each vector occupies SETTLE+2 cycles,
  // its compare is the last of them, and one DONE cycle follows the final vector.
  initial begin
    for (int i = 0; i < 3; i++) begin
      act[i] = 0; k[i] = 0; cnt_e[i] = 0; fv_e[i] = 0; fd_e[i] = 0;
      seen_e[i] = 0; done_e[i] = 0; map_e[i] = 8'h00;
    end
    forever begin
      @(posedge clk or negedge rst_n);
      for (int i = 0; i < 3; i++) begin
        int sp;
        int tot;
        int v;
        int d;
        sp  = settle_p[i] + 2;
        tot = passes_p[i] * 8 * sp + 1;
        if (!rst_n) begin
          act[i] = 0; k[i] = 0; cnt_e[i] = 0; fv_e[i] = 0; fd_e[i] = 0;
          seen_e[i] = 0; done_e[i] = 0; map_e[i] = 8'h00;
        end else if (act[i] == 0) begin
          if (start_v[i] && !abort_v[i]) begin
            act[i] = 1; k[i] = 1; cnt_e[i] = 0; fv_e[i] = 0; fd_e[i] = 0;
            seen_e[i] = 0; done_e[i] = 0; map_e[i] = 8'h00;
          end
        end else begin
          if (k[i] % sp == 0 && k[i] < tot) begin
            v = (k[i] / sp - 1) % 8;
            d = int'(inj(mode[i], v));
            if (d != 0) begin
              if (cnt_e[i] < (1 << cntw_p[i]) - 1) cnt_e[i]++;
              if (seen_e[i] == 0) begin
                seen_e[i] = 1; fv_e[i] = v; fd_e[i] = d;
              end
              map_e[i][v] = 1'b1;
            end
          end
          if (abort_v[i]) begin
            act[i] = 0; done_e[i] = 0;
          end else if (k[i] == tot) begin
            act[i] = 0; done_e[i] = 1;
          end else begin
            k[i]++;
          end
        end
      end
    end
  end

  function automatic int exp_dut_in(int i);
    int sp;
    int j;
    int g;
    if (act[i] == 0) return 0;
    sp = settle_p[i] + 2;
    j  = (k[i] - 1) % sp;
    g  = (k[i] - 1) / sp;
    if (j == 0) return (g == 0) ? 0 : (g - 1) % 8;
    return g % 8;
  endfunction

  task automatic chk_inst(int i, int busy, int done, int din, int cnt, int flag, int fv, int fd);
    string p;
    p = $sformatf("u%0d.", i);
    chk({p, "busy"}, busy, act[i]);
    chk({p, "done"}, done, done_e[i]);
    chk({p, "dut_in"}, din, exp_dut_in(i));
    chk({p, "mismatch_cnt"}, cnt, cnt_e[i]);
    chk({p, "trojan_flag"}, flag, int'(cnt_e[i] != 0));
    chk({p, "fail_vec"}, fv, fv_e[i]);
    chk({p, "fail_diff"}, fd, fd_e[i]);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      chk_inst(0, int'(b0.busy), int'(b0.done), int'(b0.dut_in), int'(b0.mismatch_cnt),
               int'(b0.trojan_flag), int'(b0.fail_vec), int'(b0.fail_diff));
      chk_inst(1, int'(b1.busy), int'(b1.done), int'(b1.dut_in), int'(b1.mismatch_cnt),
               int'(b1.trojan_flag), int'(b1.fail_vec), int'(b1.fail_diff));
      chk_inst(2, int'(b2.busy), int'(b2.done), int'(b2.dut_in), int'(b2.mismatch_cnt),
               int'(b2.trojan_flag), int'(b2.fail_vec), int'(b2.fail_diff));
`ifdef TROJAN_SCAN_MAP_EN
      chk("u0.fail_map", int'(b0.fail_map), int'(map_e[0]));
      chk("u1.fail_map", int'(b1.fail_map), int'(map_e[1]));
      chk("u2.fail_map", int'(b2.fail_map), int'(map_e[2]));
`endif
    end
  end

  function automatic logic get_busy(int i);
    case (i)
      0:       return b0.busy;
      1:       return b1.busy;
      default: return b2.busy;
    endcase
  endfunction

  task automatic pulse(int i, logic s, logic a);
    @(negedge clk);
    start_v[i] = s;
    abort_v[i] = a;
    @(negedge clk);
    start_v[i] = 1'b0;
    abort_v[i] = 1'b0;
  endtask

  // counts busy cycles; optionally re-pulses start on cycle 'mid' of the scan
  task automatic run_scan(int i, int mid, output int n);
    pulse(i, 1'b1, 1'b0);
    n = 0;
    while (get_busy(i) && n < 2000) begin
      n++;
      start_v[i] = (n == mid);
      @(negedge clk);
    end
    start_v[i] = 1'b0;
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      start_v[i] = 1'b0;
      abort_v[i] = 1'b0;
      mode[i]    = 0;
    end
    repeat (3) @(negedge clk);
    chk("reset.busy", int'(b0.busy), 0);
    chk("reset.dut_in", int'(b0.dut_in), 0);
    chk("reset.done", int'(b0.done), 0);
    chk("reset.mismatch_cnt", int'(b0.mismatch_cnt), 0);
    rst_n = 1'b1;

    run_scan(0, -1, n);
    chk("clean.busy_len", n, 33);
    chk("clean.done", int'(b0.done), 1);
    chk("clean.mismatch_cnt", int'(b0.mismatch_cnt), 0);
    chk("clean.trojan_flag", int'(b0.trojan_flag), 0);
    chk("clean.dut_in_parked", int'(b0.dut_in), 0);

    run_scan(0, 5, n);
    chk("start_while_busy.busy_len", n, 33);

    mode[0] = 1;
    run_scan(0, -1, n);
    chk("inj5.mismatch_cnt", int'(b0.mismatch_cnt), 1);
    chk("inj5.fail_vec", int'(b0.fail_vec), 5);
    chk("inj5.fail_diff", int'(b0.fail_diff), 1);
    chk("inj5.trojan_flag", int'(b0.trojan_flag), 1);
`ifdef TROJAN_SCAN_MAP_EN
    chk("inj5.fail_map", int'(b0.fail_map), 32);
`endif

    mode[1] = 1;
    run_scan(1, -1, n);
    chk("pass2.busy_len", n, 65);
    chk("pass2.mismatch_cnt", int'(b1.mismatch_cnt), 2);
    chk("pass2.fail_vec", int'(b1.fail_vec), 5);

    mode[2] = 2;
    run_scan(2, -1, n);
    chk("sat.busy_len", n, 33);
    chk("sat.mismatch_cnt", int'(b2.mismatch_cnt), 7);
    chk("sat.fail_vec", int'(b2.fail_vec), 0);
    chk("sat.fail_diff", int'(b2.fail_diff), 15);

    pulse(0, 1'b1, 1'b0);
    repeat (9) @(negedge clk);
    chk("abort.pre_dut_in", int'(b0.dut_in), 2);
    abort_v[0] = 1'b1;
    @(negedge clk);
    abort_v[0] = 1'b0;
    chk("abort.busy", int'(b0.busy), 0);
    chk("abort.done", int'(b0.done), 0);
    chk("abort.dut_in", int'(b0.dut_in), 0);
    chk("abort.mismatch_cnt", int'(b0.mismatch_cnt), 0);
    run_scan(0, -1, n);
    chk("after_abort.busy_len", n, 33);
    chk("after_abort.mismatch_cnt", int'(b0.mismatch_cnt), 1);

    mode[0] = 2;
    pulse(0, 1'b1, 1'b0);
    repeat (7) @(negedge clk);
    abort_v[0] = 1'b1;
    @(negedge clk);
    abort_v[0] = 1'b0;
    chk("abort_cmp.mismatch_cnt", int'(b0.mismatch_cnt), 2);
    chk("abort_cmp.fail_vec", int'(b0.fail_vec), 0);
    chk("abort_cmp.fail_diff", int'(b0.fail_diff), 15);
    chk("abort_cmp.busy", int'(b0.busy), 0);

    pulse(0, 1'b1, 1'b0);
    repeat (5) @(negedge clk);
    chk("midrst.pre_dut_in", int'(b0.dut_in), 1);
    chk("midrst.pre_cnt", int'(b0.mismatch_cnt), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst.busy", int'(b0.busy), 0);
    chk("midrst.dut_in", int'(b0.dut_in), 0);
    chk("midrst.mismatch_cnt", int'(b0.mismatch_cnt), 0);
    chk("midrst.trojan_flag", int'(b0.trojan_flag), 0);
    chk("midrst.fail_diff", int'(b0.fail_diff), 0);
    @(negedge clk);
    rst_n = 1'b1;

    pulse(0, 1'b1, 1'b1);
    chk("start_abort.busy", int'(b0.busy), 0);
    @(negedge clk);
    chk("start_abort.busy_later", int'(b0.busy), 0);

    $display("%0d/%0d checks passed", passed, total_checks);
    $finish;
  end
endmodule
